// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: LFSR stimulus + MISR compaction BIST controller for alu_8bit.
// Define ALU_BIST_CAPTURE_REG_EN to register the ALU response before the MISR (adds a DRAIN cycle).
module alu_bist_ctrl #(
  parameter int          PATTERN_COUNT    = 256,
  parameter logic [19:0] LFSR_SEED        = 20'h5A5A5,
  parameter logic [15:0] GOLDEN_SIGNATURE = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  operand_a,
  output logic [7:0]  operand_b,
  output logic [3:0]  operation,
  input  logic [7:0]  result,
  input  logic        carry_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  localparam int CW = $clog2(PATTERN_COUNT + 1);
  localparam logic [19:0] SEED = (LFSR_SEED == 20'h0) ? 20'h00001 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
`ifdef ALU_BIST_CAPTURE_REG_EN
  localparam state_t AFTER_RUN = DRAIN;
`else
  localparam state_t AFTER_RUN = DONE;
`endif
  state_t state, state_nx;
  logic [19:0] lfsr;
  logic [15:0] misr;
  logic [CW-1:0] cnt;
  logic go, last, absorb_en;
  logic [8:0] absorb;
  assign go = start && (state == IDLE || state == DONE);
  assign last = cnt == CW'(PATTERN_COUNT - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = go ? RUN :
               (state == RUN && last) ? AFTER_RUN :
               (state == DRAIN) ? DONE : state;
  end
`ifdef ALU_BIST_CAPTURE_REG_EN
  logic [8:0] cap;
  logic cap_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      cap   <= '0;
      cap_v <= 1'b0;
    end else begin
      cap   <= {carry_out, result};
      cap_v <= state == RUN;
    end
  end
  assign absorb = cap;
  assign absorb_en = cap_v;
`else
  assign absorb = {carry_out, result};
  assign absorb_en = state == RUN;
`endif
  always_ff @(posedge clk) begin
    if (rst || go) begin
      lfsr <= SEED;
      misr <= 16'hFFFF;
      cnt  <= '0;
    end else begin
      if (state == RUN) begin
        lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
        cnt  <= cnt + 1'b1;
      end
      if (absorb_en)
        misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {7'b0, absorb};
    end
  end
  always_comb begin
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    pass = (state == DONE) && (misr == GOLDEN_SIGNATURE);
  end
  assign operand_a = lfsr[7:0];
  assign operand_b = lfsr[15:8];
  assign operation = lfsr[19:16];
  assign signature = misr;
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb_alu_bist_ctrl: scoreboard bench for alu_bist_ctrl with a behavioural ALU and zero-response stubs.
module tb_alu_bist_ctrl;
  localparam int N = 256;
`ifdef ALU_BIST_CAPTURE_REG_EN
  localparam int LAT = N + 2;
  localparam int BUSYN = N + 1;
  localparam int LAT2 = 4;
  localparam int EXTRA = 1;
`else
  localparam int LAT = N + 1;
  localparam int BUSYN = N;
  localparam int LAT2 = 3;
  localparam int EXTRA = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [7:0] a, b, res, zr8;
  logic [3:0] op;
  logic carry, zr1, busy, done, pass;
  logic [15:0] sig;
  logic [7:0] a2, b2, a3, b3;
  logic [3:0] op2, op3;
  logic busy2, done2, pass2, busy3, done3, pass3;
  logic [15:0] sig2, sig3;
  int total = 0, bad = 0;
  logic [19:0] pat_q[$];
  logic [15:0] sig_q[$];

  always #5 clk = ~clk;
  assign zr8 = 8'h00;
  assign zr1 = 1'b0;

  function automatic logic [8:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [3:0] o);
    case (o)
      4'h0: return {1'b0, x} + {1'b0, y};
      4'h1: return {1'b0, x} - {1'b0, y};
      4'h2: return {1'b0, x & y};
      4'h3: return {1'b0, x | y};
      4'h4: return {1'b0, x ^ y};
      4'h5: return {1'b0, ~x};
      4'h6: return {x, 1'b0};
      4'h7: return {x[0], 1'b0, x[7:1]};
      default: return {1'b0, x} + {1'b0, y} + 9'd1;
    endcase
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [8:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {7'b0, d};
  endfunction

  assign {carry, res} = alu(a, b, op);

  alu_bist_ctrl #(.PATTERN_COUNT(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .operand_a(a), .operand_b(b), .operation(op),
    .result(res), .carry_out(carry), .busy(busy), .done(done), .pass(pass), .signature(sig));
  alu_bist_ctrl #(.PATTERN_COUNT(2), .GOLDEN_SIGNATURE(16'hCF9F)) u_p2 (
    .clk(clk), .rst(rst), .start(start2), .operand_a(a2), .operand_b(b2), .operation(op2),
    .result(zr8), .carry_out(zr1), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));
  alu_bist_ctrl #(.PATTERN_COUNT(2), .GOLDEN_SIGNATURE(16'hCF9E)) u_f2 (
    .clk(clk), .rst(rst), .start(start2), .operand_a(a3), .operand_b(b3), .operation(op3),
    .result(zr8), .carry_out(zr1), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pat"}, {12'h0, op, b, a}, 32'h5A5A5);
    chk({tag, "_flags"}, {busy, done, pass}, 3'b000);
    chk({tag, "_sig"}, sig, 16'hFFFF);
  endtask

  task automatic run_main(input bit glitch, input bit done_before);
    logic [19:0] x = 20'h5A5A5;
    logic [15:0] m = 16'hFFFF;
    int c = 1, busy_cnt = 0;
    bit got = 0;
    for (int i = 0; i < N; i++) begin
      pat_q.push_back(x);
      m = misr_step(m, alu(x[7:0], x[15:8], x[19:16]));
      x = {x[18:0], x[19] ^ x[16]};
    end
    sig_q.push_back(m);
    @(negedge clk);
    chk("done_before", done, done_before);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (c <= LAT + 8 && !got) begin
      if (c == 1) chk("done_drop", done, 1'b0);
      if (c == 1) chk("pat0_const", {12'h0, op, b, a}, 32'h5A5A5);
      if (c == 2) chk("pat1_const", {12'h0, op, b, a}, 32'hB4B4B);
      if (busy) busy_cnt++;
      if (busy && pat_q.size() > 0) chk("pat", {op, b, a}, pat_q.pop_front());
      start = glitch && (c == 10 || c == N);
      if (done) begin
        got = 1;
        m = sig_q.pop_front();
        chk("lag", c, LAT);
        chk("busy_len", busy_cnt, BUSYN);
        chk("sig", sig, m);
        chk("pass", pass, m == 16'h0000);
        repeat (3) @(negedge clk);
        chk("sig_hold", {done, sig}, {1'b1, m});
      end else begin
        c++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 1'b0, 1'b1);
    chk("pat_left", pat_q.size(), 0);
    pat_q.delete();
    sig_q.delete();
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset2", {busy2, done2, pass2, sig2}, {3'b000, 16'hFFFF});
    rst = 1'b0;
    // N=2 with an all-zero ALU response
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("s2_busy", busy2, 1'b1);
    chk("s2_sig0", sig2, 16'hFFFF);
    repeat (1 + EXTRA) @(negedge clk);
    chk("s2_sig1", sig2, 16'hEFDF);
    c = 2 + EXTRA;
    while (!done2 && c < 12) begin
      @(negedge clk);
      c++;
    end
    chk("s2_lag", c, LAT2);
    chk("s2_final", sig2, 16'hCF9F);
    chk("s2_pass", pass2, 1'b1);
    chk("s2_fail_sig", sig3, 16'hCF9F);
    chk("s2_fail_pass", {done3, pass3}, 2'b10);
    chk_idle("idle_hold");
    run_main(1'b0, 1'b0);
    run_main(1'b1, 1'b1);
    // reset mid-run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk_idle("mid_rst");
    @(negedge clk);
    chk_idle("post_rst");
    run_main(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_bist_ctrl.md
# alu_bist_ctrl

Built-in self-test controller for the 8-bit ALU (`alu_8bit`).
- Drives pseudo-random `operand_a`, `operand_b` and `operation` from an LFSR.
- Compacts the ALU's `result` and `carry_out` into a MISR signature and compares it with a golden value.
- Sits beside `alu_8bit` in place of the simulation stimulus; produces a pass/fail flag usable on silicon.

## Interface
- `PATTERN_COUNT`, 256: number of patterns per run; legal range 1..65535.
- `LFSR_SEED`, 20'h5A5A5: LFSR load value at reset and at each start. Zero is illegal; if zero, load 20'h00001 instead.
- `GOLDEN_SIGNATURE`, 16'h0000: expected final MISR value.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle run request.
- `operand_a` output 8: to ALU; equals `lfsr[7:0]`.
- `operand_b` output 8: to ALU; equals `lfsr[15:8]`.
- `operation` output 4: to ALU; equals `lfsr[19:16]`.
- `result` input 8: from ALU (combinational response).
- `carry_out` input 1: from ALU.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: high in DONE; sticky until the next start or reset.
- `pass` output 1: `done && (signature == GOLDEN_SIGNATURE)`.
- `signature` output 16: current MISR contents.

## Operation
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: after `PATTERN_COUNT` cycles → DRAIN if `ALU_BIST_CAPTURE_REG_EN` is defined, else → DONE.
  - DRAIN: 1 cycle → DONE.
  - DONE: `start` → RUN.
- `start` in IDLE or DONE:
  - LFSR reloads the seed, MISR loads 16'hFFFF, pattern counter clears.
  - `done` and `pass` drop the next cycle.
- `start` while `busy` is ignored.
- LFSR:
  - 20-bit Fibonacci, polynomial x^20+x^17+1.
  - Next state is `{lfsr[18:0], lfsr[19]^lfsr[16]}`.
  - Advances once per RUN cycle only; holds in all other states.
- MISR:
  - CRC-CCITT feedback.
  - Next state is `{m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 0) ^ {7'b0, carry_out, result}`.
  - Input vector is 9 bits, zero-extended to 16.
- Pattern counter: width `$clog2(PATTERN_COUNT+1)`; counts RUN cycles; terminal at `PATTERN_COUNT`.
- Reset (any state, including mid-run) → IDLE with:
  - LFSR = seed, so ALU outputs equal the seed fields.
  - MISR = 16'hFFFF.
  - `busy`=0, `done`=0, `pass`=0.
  - Capture register and its valid flag cleared.

## Timing
- `start` sampled at edge k:
  - `busy`=1 from cycle k+1.
  - Pattern i is presented on cycle k+1+i, for i = 0..N-1; pattern 0 is the seed.
- Without capture register:
  - MISR absorbs the ALU response at the end of each RUN cycle, i.e. the same cycle the pattern is presented.
  - `done`=1 and final `signature` from cycle k+N+1.
- With capture register:
  - The response is registered at the end of each RUN cycle.
  - MISR absorbs the registered value one cycle later, gated by the valid flag.
  - The last absorb happens in DRAIN.
  - `done`=1 from cycle k+N+2.
- `pass` is valid in the same cycle as `done`; `signature` is stable while in DONE.
- `start` asserted in the same cycle as `rst`: reset wins.

## Configuration
- `ALU_BIST_CAPTURE_REG_EN` defined:
  - 9-bit register between ALU outputs and MISR, to break the ALU combinational path.
  - DRAIN state present; latency N+2.
- Not defined:
  - MISR fed directly from `result`/`carry_out`.
  - No DRAIN state; latency N+1.
- The final signature is identical in both builds.

## Test plan
- Reset, then idle:
  - `operand_a`=8'hA5, `operand_b`=8'hA5, `operation`=4'h5.
  - `busy`=0, `done`=0, `pass`=0, `signature`=16'hFFFF.
- Pulse `start`, default seed:
  - Pattern 0 is a=A5, b=A5, op=5.
  - Pattern 1 is a=4B, b=B4, op=B.
  - `busy` high exactly N cycles (N+1 with macro).
- `PATTERN_COUNT`=2, ALU stub returns all zeros:
  - `signature` 16'hEFDF after pattern 0.
  - Final `signature` 16'hCF9F.
  - `pass`=1 when `GOLDEN_SIGNATURE`=16'hCF9F; `pass`=0 when it is 16'hCF9E.
- Run with the real `alu_8bit`, then a second `start` from DONE:
  - Same signature both runs.
  - `done` drops one cycle after `start`.
- Assert `rst` mid-RUN:
  - Next cycle IDLE with all reset values.
  - `start` pulses during `busy` do not extend or restart the run.
- Both builds, with and without `ALU_BIST_CAPTURE_REG_EN`:
  - Same final signature for N=256.
  - `done` lag differs by exactly one cycle.
